mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory pipeline stage. ALU results with no memory operation
//               retire one cycle after acceptance. LOAD/STORE launch a single
//               held data-memory request and stall upstream until dmem_ack.
//
//               Optional build macro MEM_TIMEOUT_EN adds a watchdog: after
//               TIMEOUT_CYCLES WAIT edges without dmem_ack the access is
//               aborted, retired with wb_data=0 / no register write, and
//               mem_error pulses for one cycle. Without the macro the stage
//               waits indefinitely and mem_error is constant 0.
//
// Ports       : clk, reset (async, active-high)
//               in_valid, alu_output, store_data, mem_operation,
//               in_dest_register_enable, in_passthrough_dest_register_number
//                   - instruction from the ALU stage
//               dmem_req/we/addr/wdata, dmem_rdata, dmem_ack
//                   - data-memory request/response handshake
//               stall    - upstream must hold its outputs while high
//               out_valid, wb_data, out_dest_register_enable,
//               out_passthrough_dest_register_number - writeback results
//               mem_error - one-cycle access-timeout pulse
// Parameters  : TIMEOUT_CYCLES (1..31, default 16)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_output,
    input  logic [31:0] store_data,
    input  logic [1:0]  mem_operation,
    input  logic        in_dest_register_enable,
    input  logic [4:0]  in_passthrough_dest_register_number,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] wb_data,
    output logic        out_dest_register_enable,
    output logic [4:0]  out_passthrough_dest_register_number,
    output logic        mem_error
);

    localparam logic [1:0] c_op_load  = 2'd1;
    localparam logic [1:0] c_op_store = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_pend_en;   // destination enable of the in-flight access
    logic [4:0] r_pend_rd;   // destination register of the in-flight access

    logic w_is_mem_op;
    assign w_is_mem_op = (mem_operation == c_op_load) || (mem_operation == c_op_store);

    // Upstream is frozen for the whole time a memory access is outstanding.
    assign stall = (r_state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    // Counter value seen on the edge that completes TIMEOUT_CYCLES WAIT edges.
    localparam logic [4:0] c_timeout_last = 5'(TIMEOUT_CYCLES - 1);
    logic [4:0] r_timer;
`else
    // Reads 0 for every legal TIMEOUT_CYCLES; referencing the parameter keeps
    // it meaningful in builds without the watchdog.
    assign mem_error = (TIMEOUT_CYCLES < 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                              <= S_IDLE;
            r_pend_en                            <= 1'b0;
            r_pend_rd                            <= 5'd0;
            dmem_req                             <= 1'b0;
            dmem_we                              <= 1'b0;
            dmem_addr                            <= 32'd0;
            dmem_wdata                           <= 32'd0;
            out_valid                            <= 1'b0;
            wb_data                              <= 32'd0;
            out_dest_register_enable             <= 1'b0;
            out_passthrough_dest_register_number <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            mem_error                            <= 1'b0;
            r_timer                              <= 5'd0;
`endif
        end else begin
            // Retire strobes are single-cycle; the register-file enable is
            // never allowed to outlive out_valid.
            out_valid                <= 1'b0;
            out_dest_register_enable <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_error                <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // dmem_ack is deliberately not looked at here.
                    if (in_valid) begin
                        if (w_is_mem_op) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (mem_operation == c_op_store);
                            dmem_addr  <= alu_output;
                            dmem_wdata <= store_data;
                            r_pend_en  <= in_dest_register_enable;
                            r_pend_rd  <= in_passthrough_dest_register_number;
`ifdef MEM_TIMEOUT_EN
                            r_timer    <= 5'd0;
`endif
                            r_state    <= S_WAIT;
                        end else begin
                            out_valid                            <= 1'b1;
                            wb_data                              <= alu_output;
                            out_dest_register_enable             <= in_dest_register_enable;
                            out_passthrough_dest_register_number <= in_passthrough_dest_register_number;
                        end
                    end
                end

                S_WAIT: begin
                    // Request fields are left untouched so they stay stable
                    // until the ack is seen; ack wins over a coincident timeout.
                    if (dmem_ack) begin
                        dmem_req                             <= 1'b0;
                        out_valid                            <= 1'b1;
                        wb_data                              <= dmem_we ? 32'd0 : dmem_rdata;
                        out_dest_register_enable             <= dmem_we ? 1'b0 : r_pend_en;
                        out_passthrough_dest_register_number <= r_pend_rd;
                        r_state                              <= S_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_timer == c_timeout_last) begin
                        dmem_req                             <= 1'b0;
                        out_valid                            <= 1'b1;
                        wb_data                              <= 32'd0;
                        out_passthrough_dest_register_number <= r_pend_rd;
                        mem_error                            <= 1'b1;
                        r_state                              <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 5'd1;
                    end
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. A transaction-level model
//               predicts stall, request fields and retire results on every
//               cycle; directed sequences add hand-computed literal checks.
//               Watchdog scenarios are enabled when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int TMO = 16;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_output = '0;
    logic [31:0] store_data = '0;
    logic [1:0]  mem_operation = '0;
    logic        in_en = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall, out_valid, out_en, mem_error;
    logic [31:0] wb_data;
    logic [4:0]  out_rd;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                                  (clk),
        .reset                                (reset),
        .in_valid                             (in_valid),
        .alu_output                           (alu_output),
        .store_data                           (store_data),
        .mem_operation                        (mem_operation),
        .in_dest_register_enable              (in_en),
        .in_passthrough_dest_register_number  (in_rd),
        .dmem_req                             (dmem_req),
        .dmem_we                              (dmem_we),
        .dmem_addr                            (dmem_addr),
        .dmem_wdata                           (dmem_wdata),
        .dmem_rdata                           (dmem_rdata),
        .dmem_ack                             (dmem_ack),
        .stall                                (stall),
        .out_valid                            (out_valid),
        .wb_data                              (wb_data),
        .out_dest_register_enable             (out_en),
        .out_passthrough_dest_register_number (out_rd),
        .mem_error                            (mem_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One outstanding memory transaction at most; it ages by one per clock
    // and ends on ack or when it reaches the timeout age.
    bit          m_busy = 0;
    int          m_age = 0;
    bit          m_store = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    bit          m_en = 0;
    logic [4:0]  m_rd = '0;
    bit          e_valid = 0, e_en = 0, e_err = 0, e_rd_known = 1;
    logic [31:0] e_wb = '0;
    logic [4:0]  e_rd = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_age = 0; m_store = 0; m_addr = '0; m_wdata = '0;
            m_en = 0; m_rd = '0;
            e_valid = 0; e_en = 0; e_err = 0; e_wb = '0; e_rd = '0; e_rd_known = 1;
        end else begin
            e_valid = 0; e_en = 0; e_err = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (mem_operation == 2'd1 || mem_operation == 2'd2) begin
                        m_busy = 1; m_age = 0;
                        m_store = (mem_operation == 2'd2);
                        m_addr = alu_output; m_wdata = store_data;
                        m_en = in_en; m_rd = in_rd;
                    end else begin
                        e_valid = 1; e_wb = alu_output; e_en = in_en;
                        e_rd = in_rd; e_rd_known = 1;
                    end
                end
            end else begin
                m_age++;
                if (dmem_ack) begin
                    m_busy = 0; e_valid = 1;
                    e_wb = m_store ? 32'd0 : dmem_rdata;
                    e_en = m_store ? 1'b0 : m_en;
                    e_rd = m_rd; e_rd_known = 1;
                end else if (TMO_ON && m_age == TMO) begin
                    m_busy = 0; e_valid = 1; e_wb = 32'd0; e_en = 0; e_err = 1;
                    e_rd_known = 0;   // destination after an abort is not defined
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall",     stall,     m_busy);
            chk("dmem_req",  dmem_req,  m_busy);
            if (m_busy) begin
                chk("dmem_we",    dmem_we,    m_store);
                chk("dmem_addr",  dmem_addr,  m_addr);
                chk("dmem_wdata", dmem_wdata, m_wdata);
            end
            chk("out_valid", out_valid, e_valid);
            chk("out_en",    out_en,    e_en);
            chk("wb_data",   wb_data,   e_wb);
            if (e_rd_known) chk("out_rd", out_rd, e_rd);
            chk("mem_error", mem_error, e_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input bit en, input logic [4:0] rd);
        in_valid = v; mem_operation = op; alu_output = a; store_data = d;
        in_en = en; in_rd = rd;
    endtask

    task automatic idle();
        drive(0, 2'd0, 32'h0, 32'h0, 0, 5'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        step();
        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_req",   dmem_req,  0);
        chk("rst_wb",    wb_data,   0);
        chk("rst_rd",    out_rd,    0);
        chk("rst_err",   mem_error, 0);
        reset = 1'b0;
        step();

        // NONE op: retire next edge, no stall
        drive(1, 2'd0, 32'h0000_002A, 32'h0, 1, 5'd5);
        step();
        chk("none_valid", out_valid, 1);
        chk("none_wb",    wb_data,   32'h2A);
        chk("none_rd",    out_rd,    5'd5);
        chk("none_stall", stall,     0);
        idle();
        step();
        chk("idle_valid", out_valid, 0);
        chk("idle_wb_hold", wb_data, 32'h2A);

        // op=3 treated as NONE
        drive(1, 2'd3, 32'h0000_0077, 32'hFFFF_FFFF, 0, 5'd11);
        step();
        chk("op3_valid", out_valid, 1);
        chk("op3_wb",    wb_data,   32'h77);
        chk("op3_req",   dmem_req,  0);
        idle();
        step();

        // LOAD 0x100, ack three cycles after request
        drive(1, 2'd1, 32'h0000_0100, 32'h0, 1, 5'd7);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("load_stall", stall, 1);
            if (i == 2) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
            step();
        end
        dmem_ack = 1'b0;
        chk("load_valid", out_valid, 1);
        chk("load_wb",    wb_data,   32'hDEAD_BEEF);
        chk("load_en",    out_en,    1);
        chk("load_rd",    out_rd,    5'd7);
        chk("load_stall_end", stall, 0);
        step();

        // STORE 0x200 with immediate ack, NONE op held behind it
        drive(1, 2'd2, 32'h0000_0200, 32'h0000_1234, 1, 5'd9);
        step();
        chk("st_we",    dmem_we,    1);
        chk("st_addr",  dmem_addr,  32'h200);
        chk("st_wdata", dmem_wdata, 32'h1234);
        dmem_ack = 1'b1;
        drive(1, 2'd0, 32'h0000_0055, 32'h0, 1, 5'd3);
        step();
        dmem_ack = 1'b0;
        chk("st_valid", out_valid, 1);
        chk("st_en",    out_en,    0);
        chk("st_wb",    wb_data,   0);
        step();
        chk("held_valid", out_valid, 1);
        chk("held_wb",    wb_data,   32'h55);
        chk("held_rd",    out_rd,    5'd3);
        idle();
        step();

        // Spurious ack in IDLE
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        step();
        dmem_ack = 1'b0;
        chk("spur_valid", out_valid, 0);
        chk("spur_stall", stall,     0);
        step();

        // LOAD to x0 never acked: abort on 16th WAIT edge, or wait forever
        drive(1, 2'd1, 32'h0000_0300, 32'h0, 1, 5'd0);
        step();
        idle();
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_pre_valid", out_valid, 0);
        step();
        if (TMO_ON) begin
            chk("tmo_err",   mem_error, 1);
            chk("tmo_valid", out_valid, 1);
            chk("tmo_en",    out_en,    0);
            chk("tmo_wb",    wb_data,   0);
            step();
            chk("tmo_err_pulse", mem_error, 0);
        end else begin
            chk("nto_stall", stall,     1);
            chk("nto_err",   mem_error, 0);
            for (int i = 0; i < 8; i++) step();
            dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
            step();
            dmem_ack = 1'b0;
            chk("nto_valid", out_valid, 1);
            chk("x0_rd",     out_rd,    5'd0);
            chk("x0_wb",     wb_data,   32'h0BAD_F00D);
        end

        // LOAD whose ack coincides with the abort edge: normal retire
        drive(1, 2'd1, 32'h0000_0400, 32'h0, 1, 5'd12);
        step();
        idle();
        for (int i = 0; i < TMO - 1; i++) step();
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
        step();
        dmem_ack = 1'b0;
        chk("race_valid", out_valid, 1);
        chk("race_err",   mem_error, 0);
        chk("race_wb",    wb_data,   32'h1357_9BDF);
        chk("race_en",    out_en,    1);
        step();

        // Reset in the middle of WAIT
        drive(1, 2'd2, 32'h0000_0500, 32'hAAAA_5555, 1, 5'd14);
        step();
        idle();
        chk("mid_req_before", dmem_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_req",   dmem_req,   0);
        chk("mid_stall", stall,      0);
        chk("mid_addr",  dmem_addr,  0);
        chk("mid_wdata", dmem_wdata, 0);
        chk("mid_wb",    wb_data,    0);
        chk("mid_rd",    out_rd,     0);
        step();
        reset = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("mid_no_retire", out_valid, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
